// File: rtl/lut_sweep_engine_if.sv
// Lookup request / result stream bundle for the LUT sweep engine.
interface lut_sweep_engine_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [N_IN-1:0]  in_vec;
   logic             out_valid;
   logic             out_ready;
   logic [N_IN-1:0]  out_vec;
   logic [N_OUT-1:0] out_fn;

   // requester / result consumer side
   modport master (
      output in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_vec, out_fn
   );

   // engine side
   modport slave (
      input  in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_vec, out_fn
   );
endinterface

// File: rtl/lut_sweep_engine.sv
// Programmable multi-output truth table with single lookups and an
// exhaustive sweep that streams every minterm and counts ones per column.
//
// state | meaning
// IDLE  | serve lookups, accept table writes, wait for start_sweep
// SWEEP | stream minterms 0..2^N_IN-1 in order, accumulate ones counts
// DONE  | one-cycle done pulse, table writes accepted, back to IDLE
module lut_sweep_engine #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_we,
   input  logic [N_IN-1:0]           cfg_addr,
   input  logic [N_OUT-1:0]          cfg_data,
   input  logic                      start_sweep,
   output logic                      busy,
   output logic                      done,
   output logic [N_OUT*(N_IN+1)-1:0] ones_count,
   lut_sweep_engine_if.slave         bus
);
   localparam int DEPTH = 1 << N_IN;
   localparam int CW    = N_IN + 1;

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t                     state_q;
   logic [N_OUT-1:0]           tbl_q [DEPTH];
   logic                       out_valid_q;
   logic [N_IN-1:0]            out_vec_q;
   logic [N_OUT-1:0]           out_fn_q;
   logic                       busy_q;
   logic                       done_q;
   logic [N_OUT*CW-1:0]        ones_q;
   // MSB set means every sweep beat has been loaded
   logic [N_IN:0]              idx_q;

   logic out_fire;
   logic out_free;
   logic lookup_fire;

   // output register handshake and lookup acceptance
   always_comb begin
      out_fire    = out_valid_q && bus.out_ready;
      out_free    = !out_valid_q || bus.out_ready;
      bus.in_ready = (state_q == IDLE) && !start_sweep && out_free;
      lookup_fire = bus.in_valid && bus.in_ready;
   end

   // sequencer, table storage, output beat register and column counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         out_fn_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ones_q      <= '0;
         idx_q       <= '0;
         for (int k = 0; k < DEPTH; k++) tbl_q[k] <= '0;
      end else begin
         done_q <= 1'b0;
         if (out_fire) out_valid_q <= 1'b0;
         // table writes during a sweep are dropped so the sweep sees one table
         if (cfg_we && (state_q != SWEEP)) tbl_q[cfg_addr] <= cfg_data;
         case (state_q)
            IDLE: begin
               if (start_sweep && out_free) begin
                  state_q <= SWEEP;
                  busy_q  <= 1'b1;
                  idx_q   <= '0;
                  ones_q  <= '0;
               end else if (lookup_fire) begin
                  out_vec_q   <= bus.in_vec;
                  out_fn_q    <= tbl_q[bus.in_vec];
                  out_valid_q <= 1'b1;
               end
            end
            SWEEP: begin
               if (out_fire) begin
                  for (int j = 0; j < N_OUT; j++)
                     ones_q[j*CW +: CW] <= ones_q[j*CW +: CW] + {{N_IN{1'b0}}, out_fn_q[j]};
                  // only sweep beats occupy the register here, so all-ones is the last one
                  if (&out_vec_q) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               if (out_free && !idx_q[N_IN]) begin
                  out_vec_q   <= idx_q[N_IN-1:0];
                  out_fn_q    <= tbl_q[idx_q[N_IN-1:0]];
                  out_valid_q <= 1'b1;
                  idx_q       <= idx_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_vec   = out_vec_q;
   assign bus.out_fn    = out_fn_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign ones_count    = ones_q;
endmodule

// File: tb/tb_lut_sweep_engine.sv
// Scoreboard bench for lut_sweep_engine: drivers push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_lut_sweep_engine;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [2:0]  cfg_data = '0;
   logic        start_sweep = 1'b0;
   logic        busy;
   logic        done;
   logic [14:0] ones_count;

   lut_sweep_engine_if #(.N_IN(4), .N_OUT(3)) bus ();

   lut_sweep_engine #(.N_IN(4), .N_OUT(3)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .start_sweep(start_sweep), .busy(busy),
      .done(done), .ones_count(ones_count), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] vec;
      logic [2:0] fn;
      int         due;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] m_tbl [16];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         last_acc = -10;
   bit         mon_en = 1'b1;
   bit         rand_rdy = 1'b0;
   bit         stall_pend = 1'b0;
   logic [3:0] held_vec;
   logic [2:0] held_fn;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out, got no event expected event (t=%0t)", name, $time);
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // monitor: pops one expected beat per accepted output beat
   always @(negedge clk) begin
      if (!mon_en || !rst_n) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_vec", 32'(bus.out_vec), 32'(held_vec));
            check("stall_fn", 32'(bus.out_fn), 32'(held_fn));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               timeout("unexpected_beat");
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("beat_vec", 32'(bus.out_vec), 32'(e.vec));
               check("beat_fn", 32'(bus.out_fn), 32'(e.fn));
               if (e.due >= 0) check("beat_latency", cyc, e.due);
            end
            if (bus.out_vec == 4'd15) last_acc = cyc;
         end
         stall_pend = bus.out_valid && !bus.out_ready;
         held_vec   = bus.out_vec;
         held_fn    = bus.out_fn;
      end
   end

   task automatic cfg_write(input logic [3:0] a, input logic [2:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      m_tbl[a] = d;
   endtask

   task automatic do_lookup(input logic [3:0] v, input logic [2:0] exp_fn, input bit chk_due);
      bit got = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_vec   = v;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin got = 1'b1; break; end
      end
      if (!got) timeout("lookup_accept");
      else sb.push_back('{vec: v, fn: exp_fn, due: chk_due ? cyc + 1 : -1});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (sb.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("scoreboard_drain");
   endtask

   task automatic run_sweep(input bit collide, input bit wr_in_sweep, input logic [14:0] exp_cnt);
      bit got = 1'b0;
      for (int k = 0; k < 16; k++) sb.push_back('{vec: 4'(k), fn: m_tbl[k], due: -1});
      if (collide) begin bus.in_valid = 1'b1; bus.in_vec = 4'd2; end
      start_sweep = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (collide && n == 0) check("collide_in_ready", 32'(bus.in_ready), 32'd0);
         if (busy) begin got = 1'b1; break; end
      end
      start_sweep = 1'b0;
      if (!got) timeout("sweep_busy");
      got = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         if (wr_in_sweep && n == 0) begin
            cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 3'b010;
            check("sweep_in_ready", 32'(bus.in_ready), 32'd0);
         end
         @(negedge clk);
         cfg_we = 1'b0;
         if (done) begin got = 1'b1; break; end
      end
      bus.in_valid = 1'b0;
      if (!got) begin
         timeout("sweep_done");
      end else begin
         check("done_timing", cyc, last_acc + 1);
         check("done_busy", 32'(busy), 32'd0);
         check("ones_count", 32'(ones_count), 32'(exp_cnt));
         @(negedge clk);
         check("done_one_cycle", 32'(done), 32'd0);
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_vec = '0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 16; k++) m_tbl[k] = 3'b000;
      #22 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ones", 32'(ones_count), 32'd0);
      @(posedge clk); #1;
      do_lookup(4'b0110, 3'b000, 1'b1);
      drain();

      @(posedge clk); #1;
      for (int k = 0; k < 16; k++) cfg_write(4'(k), 3'(k));
      do_lookup(4'd5,  3'b101, 1'b1);
      do_lookup(4'd9,  3'b001, 1'b1);
      do_lookup(4'd15, 3'b111, 1'b1);
      drain();

      @(posedge clk); #1;
      run_sweep(1'b0, 1'b0, {5'd8, 5'd8, 5'd8});

      @(posedge clk); #1;
      for (int k = 0; k < 16; k++) cfg_write(4'(k), (k == 5) ? 3'b111 : 3'b000);
      rand_rdy = 1'b1;
      run_sweep(1'b0, 1'b0, {5'd1, 5'd1, 5'd1});
      rand_rdy = 1'b0;
      @(posedge clk); #2;
      bus.out_ready = 1'b1;

      @(posedge clk); #1;
      run_sweep(1'b1, 1'b1, {5'd1, 5'd1, 5'd1});
      @(posedge clk); #1;
      do_lookup(4'd3, 3'b000, 1'b1);
      drain();

      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = 3'b110;
      do_lookup(4'd9, 3'b000, 1'b1);
      cfg_we = 1'b0;
      m_tbl[9] = 3'b110;
      do_lookup(4'd9, 3'b110, 1'b1);
      drain();

      mon_en = 1'b0;
      @(posedge clk); #1;
      start_sweep = 1'b1;
      begin
         bit got = 1'b0;
         for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (busy) begin got = 1'b1; break; end
         end
         start_sweep = 1'b0;
         if (!got) timeout("rst_sweep_busy");
         got = 1'b0;
         for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_vec == 4'd7) begin got = 1'b1; break; end
         end
         if (!got) timeout("rst_sweep_beat7");
      end
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_ones", 32'(ones_count), 32'd0);
      #2 rst_n = 1'b1;
      sb.delete();
      for (int k = 0; k < 16; k++) m_tbl[k] = 3'b000;
      mon_en = 1'b1;
      @(posedge clk); #1;
      do_lookup(4'd5, 3'b000, 1'b1);
      drain();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lut_sweep_engine.md
Name: lut_sweep_engine

Overview:
- Parametrised, programmable multi-output Boolean function unit. Holds an N_OUT-bit truth table over N_IN inputs.
- Serves single lookups over a valid/ready stream.
- Can also run an exhaustive sweep of all 2^N_IN input combinations. The sweep streams every minterm and its outputs, and counts the ones in each output column.
- Used as the shared evaluator/checker for multi-output combinational exercises and for self-test of truth tables.

Parameters:
- N_IN, 4, number of function inputs; table depth is 2^N_IN.
- N_OUT, 3, number of function outputs; table width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_we  input  1  table write strobe.
- cfg_addr  input  N_IN  table entry (minterm index, MSB = first input) to write.
- cfg_data  input  N_OUT  output values for that minterm.
- in_valid  input  1  lookup request valid.
- in_ready  output  1  lookup request accepted when in_valid & in_ready.
- in_vec  input  N_IN  input combination to evaluate.
- start_sweep  input  1  request exhaustive sweep.
- busy  output  1  high while in SWEEP.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts beat when out_valid & out_ready.
- out_vec  output  N_IN  input combination of the current beat.
- out_fn  output  N_OUT  table outputs for out_vec.
- done  output  1  one-cycle pulse after the last sweep beat is accepted.
- ones_count  output  N_OUT*(N_IN+1)  per-output count of ones from the last sweep; field j occupies bits [j*(N_IN+1) +: N_IN+1].

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n). On reset:
  - table entries, out_vec, out_fn and ones_count = 0;
  - out_valid = 0, done = 0, busy = 0;
  - state = IDLE.
- State machine:
  - IDLE: normal operating state; serves lookups.
  - SWEEP: steps index i from 0 to 2^N_IN-1.
  - DONE: lasts exactly one cycle; done = 1, then returns to IDLE.
- Output register:
  - Holds its beat stable until accepted.
  - It is free when out_valid = 0, or when out_valid & out_ready in the same cycle.
- Lookup (IDLE only):
  - in_ready = (state == IDLE) & !start_sweep & output register free.
  - On accept: out_vec <= in_vec, out_fn <= table[in_vec], out_valid <= 1 on the next edge. Latency is 1 cycle, with full throughput under continuous out_ready.
- Sweep start:
  - start_sweep is sampled only in IDLE and has priority over in_valid in the same cycle.
  - Start is deferred while a lookup beat is still pending (register not free); start_sweep must be held until busy rises.
  - On start: ones_count <= 0, i <= 0, state <= SWEEP.
- SWEEP:
  - busy = 1.
  - Beat for i is loaded into the output register when the register is free. On each accepted beat, ones_count[j] += out_fn[j] for every j.
  - Beats are strictly in order 0..2^N_IN-1, with no gaps or repeats under out_ready backpressure.
  - out_ready held low stalls the sweep indefinitely, with the beat held stable.
  - After the beat for index 2^N_IN-1 is accepted, go to DONE.
  - in_valid, start_sweep and cfg_we are ignored throughout (in_ready = 0). Table writes are dropped, not queued.
- Counters: N_IN+1 bits each, so the maximum 2^N_IN is representable with no wrap. Values hold from DONE until the next sweep start or reset.
- Table writes:
  - Accepted in IDLE and DONE; take effect on the next edge.
  - A lookup of the same address in the same cycle returns the old value.
- Reset mid-sweep: immediate return to IDLE with all outputs cleared, no done pulse, and ones_count = 0.

Test Plan:
- Reset then lookup: after reset, lookup of in_vec = 4'b0110 -> out_fn = 3'b000 one cycle later; ones_count = 0; busy = 0.
- Program and look up: write table[k] = k[2:0] for all 16 entries, then back-to-back lookups of 5, 9, 15 with out_ready = 1 -> out_fn = 3'b101, 3'b001, 3'b111 on consecutive cycles, each 1 cycle after accept.
- Sweep:
  - Stimulus: same table; start_sweep; out_ready = 1.
  - Beats: 16 beats, out_vec = 0..15 in order.
  - done: pulses the cycle after beat 15 is accepted.
  - Counts: ones_count = {5'd8, 5'd8, 5'd8}.
- Sweep under backpressure:
  - Stimulus: table all zero except table[5] = 3'b111. Toggle out_ready pseudo-randomly.
  - Beats: all 16 beats held stable while stalled, in order, with no duplicates.
  - Counts: ones_count = {5'd1, 5'd1, 5'd1}.
- Collisions:
  - start_sweep and in_valid asserted together -> sweep wins, in_ready = 0.
  - cfg_we during SWEEP -> dropped; a later lookup returns the old value.
  - cfg_we plus same-address lookup in IDLE -> old value returned, new value on the next lookup.
- Reset mid-operation: assert rst_n = 0 during beat 7 of a sweep -> out_valid, busy and done go 0 immediately (asynchronously); ones_count = 0; the next lookup shows the table cleared.
